// File: rtl/dw_fifo_s1_sf_pkg.sv
// Shared constants for the single-clock status-flag FIFO: error-mode encodings
// and pointer sizing helper.
package dw_fifo_s1_sf_pkg;

  localparam int ERR_DIAG   = 0;
  localparam int ERR_STICKY = 1;
  localparam int ERR_PULSE  = 2;

  // Pointer width for a DEPTH-entry array; at least one bit.
  function automatic int ptrBits(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dw_fifo_s1_sf_ctl.sv
// FIFO control: read/write pointers, occupancy count, flag decode and the
// registered overflow/underflow error.
module fifo_ctl_s1_sf
  import dw_fifo_s1_sf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = 1,
  parameter int ERR_MODE = 2,
  localparam int AW      = ptrBits(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_req_n,
  input  logic          pop_req_n,
  input  logic          diag_n,
  output logic          empty,
  output logic          almost_empty,
  output logic          half_full,
  output logic          almost_full,
  output logic          full,
  output logic          error,
  output logic          wrEn,
  output logic [AW-1:0] wrAddr,
  output logic [AW-1:0] rdAddr
);

  if (DEPTH < 2 || DEPTH > 256 || AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1 ||
      AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1 || ERR_MODE < 0 || ERR_MODE > 2) begin : gParamCheck
    $error("fifo_ctl_s1_sf: illegal parameter combination");
  end

  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          pushReq, popReq, doPush, doPop;
  logic          overflow, underflow, errNext;

  assign pushReq = !push_req_n;
  assign popReq  = !pop_req_n;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign half_full    = (count >= CW'((DEPTH + 1) / 2));
  assign almost_full  = (count >= CW'(DEPTH - AF_LEVEL));

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign doPop     = popReq && !empty;
  assign doPush    = pushReq && (!full || popReq);
  assign overflow  = pushReq && full && !popReq;
  assign underflow = popReq && empty;

  assign wrEn   = doPush;
  assign wrAddr = wrPtr;
  assign rdAddr = rdPtr;

  always_comb begin
    errNext = error;
    if (ERR_MODE == ERR_PULSE) begin
      errNext = overflow | underflow;
    end else begin
      if (overflow || underflow) errNext = 1'b1;
      if (ERR_MODE == ERR_DIAG && !diag_n) errNext = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      error <= 1'b0;
    end else begin
      error <= errNext;
      if (doPush) wrPtr <= (wrPtr == AW'(DEPTH - 1)) ? '0 : wrPtr + AW'(1);
      if (doPop)  rdPtr <= (rdPtr == AW'(DEPTH - 1)) ? '0 : rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dw_fifo_s1_sf.sv
// Single-clock FIFO with status flags: storage array, write path and
// zero-latency head-of-queue read mux around the control block.
module dw_fifo_s1_sf
  import dw_fifo_s1_sf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = 1,
  parameter int ERR_MODE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic             diag_n,
  input  logic [WIDTH-1:0] data_in,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error,
  output logic [WIDTH-1:0] data_out
);

  localparam int AW = ptrBits(DEPTH);

  if (WIDTH < 1 || WIDTH > 256) begin : gWidthCheck
    $error("dw_fifo_s1_sf: WIDTH out of range");
  end

  // Handshake: push_req_n/pop_req_n low request a transfer on the next rising
  // edge; a push is taken unless full (a same-cycle pop makes room), a pop is
  // taken unless empty. data_out is the head word whenever empty is low.
  logic          wrEn;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [WIDTH-1:0] mem [DEPTH];

  fifo_ctl_s1_sf #(
    .DEPTH   (DEPTH),
    .AE_LEVEL(AE_LEVEL),
    .AF_LEVEL(AF_LEVEL),
    .ERR_MODE(ERR_MODE)
  ) uCtl (
    .clock       (clock),
    .reset       (reset),
    .push_req_n  (push_req_n),
    .pop_req_n   (pop_req_n),
    .diag_n      (diag_n),
    .empty       (empty),
    .almost_empty(almost_empty),
    .half_full   (half_full),
    .almost_full (almost_full),
    .full        (full),
    .error       (error),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .rdAddr      (rdAddr)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= data_in;
  end

  assign data_out = mem[rdAddr];

endmodule

// File: tb/tb_dw_fifo_s1_sf.sv
// Bench for dw_fifo_s1_sf: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dw_fifo_s1_sf;

  localparam int W = 32;
  localparam int D = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic push_req_n = 1'b1;
  logic pop_req_n = 1'b1;
  logic diag_n = 1'b1;
  logic [W-1:0] data_in = '0;

  logic empty, almost_empty, half_full, almost_full, full, error;
  logic [W-1:0] data_out;
  logic empty1, almost_empty1, half_full1, almost_full1, full1, error1;
  logic [W-1:0] data_out1;
  logic empty0, almost_empty0, half_full0, almost_full0, full0, error0;
  logic [W-1:0] data_out0;

  dw_fifo_s1_sf #(.WIDTH(W), .DEPTH(D), .AE_LEVEL(1), .AF_LEVEL(1), .ERR_MODE(2)) u_dut (
    .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .diag_n(1'b1), .data_in(data_in), .empty(empty), .almost_empty(almost_empty),
    .half_full(half_full), .almost_full(almost_full), .full(full), .error(error),
    .data_out(data_out));

  dw_fifo_s1_sf #(.WIDTH(W), .DEPTH(D), .AE_LEVEL(1), .AF_LEVEL(1), .ERR_MODE(1)) u_dut1 (
    .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .diag_n(1'b1), .data_in(data_in), .empty(empty1), .almost_empty(almost_empty1),
    .half_full(half_full1), .almost_full(almost_full1), .full(full1), .error(error1),
    .data_out(data_out1));

  dw_fifo_s1_sf #(.WIDTH(W), .DEPTH(D), .AE_LEVEL(1), .AF_LEVEL(1), .ERR_MODE(0)) u_dut0 (
    .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .diag_n(diag_n), .data_in(data_in), .empty(empty0), .almost_empty(almost_empty0),
    .half_full(half_full0), .almost_full(almost_full0), .full(full0), .error(error0),
    .data_out(data_out0));

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  bit exp_err2, exp_err1, exp_err0;
  bit check_en = 1'b0;
  int checks = 0;
  int failures = 0;
  int n_c;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clock) begin
    if (check_en) begin
      n_c = exp_q.size();
      chk("empty", W'(empty), W'(n_c == 0));
      chk("almost_empty", W'(almost_empty), W'(n_c <= 1));
      chk("half_full", W'(half_full), W'(n_c >= (D + 1) / 2));
      chk("almost_full", W'(almost_full), W'(n_c >= D - 1));
      chk("full", W'(full), W'(n_c == D));
      chk("error_pulse", W'(error), W'(exp_err2));
      chk("error_sticky", W'(error1), W'(exp_err1));
      chk("error_diag", W'(error0), W'(exp_err0));
      chk("empty_m1", W'(empty1), W'(n_c == 0));
      chk("full_m0", W'(full0), W'(n_c == D));
      if (n_c > 0) begin
        chk("data_out", data_out, exp_q[0]);
        chk("data_out_m1", data_out1, exp_q[0]);
        chk("data_out_m0", data_out0, exp_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit push, input bit pop, input logic [W-1:0] din, input bit diag);
    bit ov, un, dpush, dpop;
    int n;
    @(negedge clock);
    #1;
    push_req_n = !push;
    pop_req_n  = !pop;
    data_in    = din;
    diag_n     = !diag;
    n     = exp_q.size();
    ov    = push && (n == D) && !pop;
    un    = pop && (n == 0);
    dpop  = pop && (n != 0);
    dpush = push && ((n < D) || pop);
    @(posedge clock);
    #1;
    if (dpop) void'(exp_q.pop_front());
    if (dpush) exp_q.push_back(din);
    exp_err2 = ov | un;
    exp_err1 = exp_err1 | ov | un;
    exp_err0 = exp_err0 | ov | un | diag;
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
    diag_n     = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Asserts reset between edges and checks the flags clear without a clock.
  task automatic do_reset();
    @(negedge clock);
    #2;
    check_en = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    exp_err2 = 0;
    exp_err1 = 0;
    exp_err0 = 0;
    #1;
    chk("async_reset_empty", W'(empty), W'(1));
    chk("async_reset_full", W'(full), W'(0));
    @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    check_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v;
    int pp, qp;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_empty", W'(empty), W'(1));
    chk("reset_almost_empty", W'(almost_empty), W'(1));
    chk("reset_half_full", W'(half_full), W'(0));
    chk("reset_almost_full", W'(almost_full), W'(0));
    chk("reset_full", W'(full), W'(0));
    chk("reset_error", W'(error), W'(0));
    reset = 1'b0;
    check_en = 1'b1;
    idle();

    // first words
    step(1, 0, 32'hA0000001, 0);
    chk("lit_first_empty", W'(empty), W'(0));
    chk("lit_first_ae", W'(almost_empty), W'(1));
    chk("lit_first_data", data_out, 32'hA0000001);
    step(1, 0, 32'hA0000002, 0);
    chk("lit_second_ae", W'(almost_empty), W'(0));
    chk("lit_second_hf", W'(half_full), W'(1));

    // mid-stream asynchronous reset with two words queued
    do_reset();

    // fill, overflow, push-with-pop while full
    step(1, 0, 32'h11, 0);
    step(1, 0, 32'h22, 0);
    step(1, 0, 32'h33, 0);
    chk("lit_af_at3", W'(almost_full), W'(1));
    chk("lit_full_at3", W'(full), W'(0));
    step(1, 0, 32'h44, 0);
    chk("lit_full_at4", W'(full), W'(1));
    step(1, 0, 32'h55, 0);
    chk("lit_overflow_err", W'(error), W'(1));
    chk("lit_overflow_head", data_out, 32'h11);
    idle();
    chk("lit_overflow_err_clear", W'(error), W'(0));
    step(1, 1, 32'h55, 0);
    chk("lit_fullpp_head", data_out, 32'h22);
    chk("lit_fullpp_full", W'(full), W'(1));
    chk("lit_fullpp_err", W'(error), W'(0));
    for (int i = 0; i < 4; i++) step(0, 1, '0, 0);
    chk("lit_drained_empty", W'(empty), W'(1));

    // underflow, push+pop on empty
    step(0, 1, '0, 0);
    chk("lit_underflow_err", W'(error), W'(1));
    idle();
    chk("lit_underflow_clear", W'(error), W'(0));
    chk("lit_sticky_holds", W'(error1), W'(1));
    step(1, 1, 32'h66, 0);
    chk("lit_emptypp_data", data_out, 32'h66);
    chk("lit_emptypp_err", W'(error), W'(1));
    step(0, 1, '0, 0);

    // pointer wrap
    do_reset();
    v = 32'h100;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin step(1, 0, v, 0); v++; end
      for (int k = 0; k < 3; k++) step(0, 1, '0, 0);
    end

    // diag injection on the mode-0 instance only
    do_reset();
    step(0, 0, '0, 1);
    chk("lit_diag_err0", W'(error0), W'(1));
    chk("lit_diag_err1", W'(error1), W'(0));

    // randomized traffic with varying push/pop bias
    for (int b = 0; b < 4; b++) begin
      do_reset();
      pp = 30 + b * 15;
      qp = 75 - b * 15;
      repeat (150) begin
        step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < qp,
             $urandom, $urandom_range(0, 59) == 0);
      end
    end

    idle();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
